// File: rtl/mmio_responder.sv
// MMIO slave: fixed 32-byte window with GPIO, free-running timer/compare
// and a FIFO-fed 8N1 UART transmitter.
module mmio_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          GPIO_W       = 8,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       memaddr,
  input  logic [31:0]       memin,
  input  logic              memwrite,
  input  logic [3:0]        iobytes,
  output logic [31:0]       memout,
  output logic              sel,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              uart_tx,
  output logic              irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int KW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic [31:0]       lane_mask, gpio_out_ext, gpio_in_ext, gpio_wr, timer, timer_cmp;
  logic [GPIO_W-1:0] gpio_s1, gpio_s2;
  logic              wr, wr_gpio, wr_timer, wr_cmp, wr_uart, wr_status;
  logic              push_req, push, pop, fifo_full, fifo_empty;
  logic              overflow, match, clr_ovf, clr_match, tx_busy, line;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  tx_state_t         state, state_n;
  logic [KW-1:0]     clk_cnt, clk_cnt_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [7:0]        shreg, shreg_n;
  logic              unused_bits;

  assign sel       = (memaddr[31:5] == BASE_ADDR[31:5]);
  assign wr        = memwrite & sel;
  assign wr_gpio   = wr & (memaddr[4:2] == 3'd0);
  assign wr_timer  = wr & (memaddr[4:2] == 3'd2);
  assign wr_cmp    = wr & (memaddr[4:2] == 3'd3);
  assign wr_uart   = wr & (memaddr[4:2] == 3'd4);
  assign wr_status = wr & (memaddr[4:2] == 3'd5);

  always_comb begin
    for (int k = 0; k < 4; k++) lane_mask[8*k +: 8] = {8{iobytes[k]}};
  end

  always_comb begin
    gpio_out_ext = '0;
    gpio_in_ext  = '0;
    gpio_out_ext[GPIO_W-1:0] = gpio_out;
    gpio_in_ext[GPIO_W-1:0]  = gpio_s2;
  end

  assign gpio_wr     = (gpio_out_ext & ~lane_mask) | (memin & lane_mask);
  assign unused_bits = ^{memaddr[1:0], gpio_wr};

  always_ff @(posedge clk) begin
    if (!rst) begin
      gpio_out <= '0;
      gpio_s1  <= '0;
      gpio_s2  <= '0;
    end else begin
      gpio_s1 <= gpio_in;
      gpio_s2 <= gpio_s1;
      if (wr_gpio) gpio_out <= gpio_wr[GPIO_W-1:0];
    end
  end

  // A timer write replaces the increment; unwritten lanes keep the old value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timer     <= '0;
      timer_cmp <= '1;
    end else begin
      if (wr_timer) timer <= (timer & ~lane_mask) | (memin & lane_mask);
      else          timer <= timer + 32'd1;
      if (wr_cmp) timer_cmp <= (timer_cmp & ~lane_mask) | (memin & lane_mask);
    end
  end

  assign clr_ovf   = wr_status & iobytes[0] & memin[3];
  assign clr_match = wr_status & iobytes[0] & memin[4];

  // Set has priority over a coincident clear on both sticky flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      match    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (timer == timer_cmp) match <= 1'b1;
      else if (clr_match)     match <= 1'b0;
      if (push_req && fifo_full) overflow <= 1'b1;
      else if (clr_ovf)          overflow <= 1'b0;
    end
  end

  assign irq = match;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push_req   = wr_uart & iobytes[0];
  assign push       = push_req & ~fifo_full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= memin[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      uart_tx <= line;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt + KW'(1);
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    pop       = 1'b0;
    line      = 1'b1;
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_mem[rd_ptr];
          state_n = START;
        end
      end
      START: begin
        line = 1'b0;
        if (clk_cnt == KW'(CLKS_PER_BIT - 1)) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        line = shreg[0];
        if (clk_cnt == KW'(CLKS_PER_BIT - 1)) begin
          clk_cnt_n = '0;
          shreg_n   = {1'b0, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == KW'(CLKS_PER_BIT - 1)) begin
          clk_cnt_n = '0;
          // Back-to-back frames: reload straight from the FIFO with no idle bit.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_n = fifo_mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx_busy = (state != IDLE);

  always_comb begin
    memout = '0;
    if (sel) begin
      case (memaddr[4:2])
        3'd0:    memout = gpio_out_ext;
        3'd1:    memout = gpio_in_ext;
        3'd2:    memout = timer;
        3'd3:    memout = timer_cmp;
        3'd5:    memout = {27'd0, match, overflow, tx_busy, fifo_empty, fifo_full};
        default: memout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Randomised self-checking bench for mmio_responder against a timeline/queue model.
module tb_mmio_responder;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int GW = 8, CPB = 4, DEPTH = 4;
  localparam logic [31:0] A_GOUT = BASE + 32'h00, A_GIN = BASE + 32'h04,
                          A_TMR  = BASE + 32'h08, A_CMP = BASE + 32'h0C,
                          A_UTX  = BASE + 32'h10, A_STAT = BASE + 32'h14;

  logic          clk = 1'b0, rst = 1'b0;
  logic [31:0]   memaddr = BASE, memin = '0, memout;
  logic          memwrite = 1'b0, sel, uart_tx, irq;
  logic [3:0]    iobytes = 4'hF;
  logic [GW-1:0] gpio_in = '0, gpio_out;

  int n_checks = 0, n_pass = 0, cyc = 0;
  logic [31:0] t_val = '0;
  int          t_cyc = 0;
  logic [GW-1:0] m_gpio = '0;
  logic [7:0]  frame_q [$];

  mmio_responder #(.BASE_ADDR(BASE), .GPIO_W(GW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .memaddr(memaddr), .memin(memin), .memwrite(memwrite),
    .iobytes(iobytes), .memout(memout), .sel(sel), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .uart_tx(uart_tx), .irq(irq));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] lmask(input logic [3:0] be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  // Timer value = last loaded value plus edges elapsed since the load.
  function automatic logic [31:0] model_timer();
    return t_val + 32'(cyc - t_cyc);
  endfunction

  // Expected line k edges after the first UART_TX write edge.
  function automatic logic exp_line(input int k);
    int idx, f, b;
    if (k < 2) return 1'b1;
    idx = k - 2;
    f = idx / (10 * CPB);
    if (f >= frame_q.size()) return 1'b1;
    b = (idx % (10 * CPB)) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return frame_q[f][b-1];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] pre, m, g;
    @(negedge clk);
    memaddr = addr; memin = d; iobytes = be; memwrite = 1'b1;
    pre = model_timer();
    m = lmask(be);
    @(posedge clk); #1;
    memwrite = 1'b0;
    if (addr[31:5] == BASE[31:5]) begin
      if (addr[4:2] == 3'd0) begin
        g = '0;
        g[GW-1:0] = m_gpio;
        g = (g & ~m) | (d & m);
        m_gpio = g[GW-1:0];
      end
      if (addr[4:2] == 3'd2) begin
        t_val = (pre & ~m) | (d & m);
        t_cyc = cyc;
      end
    end
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
    memaddr = addr;
    #1;
    d = memout;
  endtask

  task automatic sample_line(input int nk, input bit chk_busy);
    logic [31:0] r;
    @(negedge clk);
    @(posedge clk);
    for (int k = 1; k <= nk; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (uart_tx !== exp_line(k)) $display("FAIL uart_line k=%0d got=%b exp=%b", k, uart_tx, exp_line(k));
      else n_pass++;
      if (chk_busy) begin
        bus_read(A_STAT, r);
        n_checks++;
        if (r[2] !== (k <= 10 * CPB)) $display("FAIL tx_busy k=%0d got=%b exp=%b", k, r[2], (k <= 10 * CPB));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b0;
    idle(2);
    t_val = '0; t_cyc = cyc; m_gpio = '0;
    n_checks++; if (gpio_out !== '0) $display("FAIL rst_gpio got=%h exp=0", gpio_out); else n_pass++;
    n_checks++; if (uart_tx !== 1'b1) $display("FAIL rst_uart got=%b exp=1", uart_tx); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL rst_irq got=%b exp=0", irq); else n_pass++;
    bus_read(A_STAT, r);
    n_checks++; if (r !== 32'h2) $display("FAIL rst_status got=%h exp=2", r); else n_pass++;
    bus_read(A_CMP, r);
    n_checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL rst_cmp got=%h exp=ffffffff", r); else n_pass++;
    bus_read(A_TMR, r);
    n_checks++; if (r !== 32'h0) $display("FAIL rst_timer got=%h exp=0", r); else n_pass++;
    n_checks++; if (sel !== 1'b1) $display("FAIL rst_sel got=%b exp=1", sel); else n_pass++;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_gpio();
    logic [31:0] r, d;
    logic [3:0] be;
    logic [GW-1:0] v, prev;
    bus_write(A_GOUT, 32'hA5A5_A5A5, 4'hF);
    n_checks++; if (gpio_out !== 8'hA5) $display("FAIL gpio_word got=%h exp=a5", gpio_out); else n_pass++;
    bus_write(A_GOUT, 32'h0000_003C, 4'b0001);
    n_checks++; if (gpio_out !== 8'h3C) $display("FAIL gpio_byte got=%h exp=3c", gpio_out); else n_pass++;
    bus_read(A_GOUT, r);
    n_checks++; if (r !== 32'h3C) $display("FAIL gpio_read got=%h exp=3c", r); else n_pass++;
    bus_write(BASE + 32'h20, $urandom, 4'hF);
    #1;
    n_checks++; if (sel !== 1'b0) $display("FAIL oow_sel got=%b exp=0", sel); else n_pass++;
    n_checks++; if (memout !== '0) $display("FAIL oow_memout got=%h exp=0", memout); else n_pass++;
    n_checks++; if (gpio_out !== 8'h3C) $display("FAIL oow_gpio got=%h exp=3c", gpio_out); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      be = 4'($urandom_range(0, 15));
      bus_write(A_GOUT, d, be);
      bus_read(A_GOUT, r);
      n_checks++;
      if (r !== 32'(m_gpio)) $display("FAIL gpio_rand got=%h exp=%h", r, m_gpio); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(BASE + 32'(16 + 4 * (i == 0 ? 0 : i + 1)), r);
      n_checks++; if (r !== '0) $display("FAIL reserved_read got=%h exp=0", r); else n_pass++;
    end
    prev = gpio_in;
    for (int i = 0; i < 3; i++) begin
      v = GW'($urandom);
      @(negedge clk) gpio_in = v;
      idle(1);
      bus_read(A_GIN, r);
      n_checks++; if (r !== 32'(prev)) $display("FAIL gpio_in_lat1 got=%h exp=%h", r, prev); else n_pass++;
      idle(1);
      bus_read(A_GIN, r);
      n_checks++; if (r !== 32'(v)) $display("FAIL gpio_in_lat2 got=%h exp=%h", r, v); else n_pass++;
      prev = v;
    end
  endtask

  task automatic test_timer();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 20));
      bus_read(A_TMR, r);
      n_checks++; if (r !== model_timer()) $display("FAIL timer_run got=%h exp=%h", r, model_timer()); else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      bus_write(A_TMR, $urandom, 4'($urandom_range(1, 15)));
      bus_read(A_TMR, r);
      n_checks++; if (r !== model_timer()) $display("FAIL timer_wr got=%h exp=%h", r, model_timer()); else n_pass++;
      idle(3);
      bus_read(A_TMR, r);
      n_checks++; if (r !== model_timer()) $display("FAIL timer_wr_run got=%h exp=%h", r, model_timer()); else n_pass++;
    end
    bus_write(A_TMR, 32'h0000_01FD, 4'hF);
    idle(1);
    bus_write(A_TMR, 32'h0000_00FF, 4'b0001);
    bus_read(A_TMR, r);
    n_checks++; if (r !== 32'h1FF) $display("FAIL timer_lane0 got=%h exp=1ff", r); else n_pass++;
    idle(1);
    bus_read(A_TMR, r);
    n_checks++; if (r !== 32'h200) $display("FAIL timer_lane0_next got=%h exp=200", r); else n_pass++;
    bus_write(A_TMR, 32'hFFFF_FFFE, 4'hF);
    idle(2);
    bus_read(A_TMR, r);
    n_checks++; if (r !== 32'h0) $display("FAIL timer_wrap got=%h exp=0", r); else n_pass++;
  endtask

  task automatic test_compare();
    logic [31:0] r;
    bus_write(A_STAT, 32'h18, 4'b0001);
    bus_write(A_CMP, 32'd10, 4'hF);
    bus_write(A_TMR, 32'd0, 4'hF);
    n_checks++; if (irq !== 1'b0) $display("FAIL cmp_pre got=%b exp=0", irq); else n_pass++;
    for (int n = 1; n <= 12; n++) begin
      idle(1);
      n_checks++;
      if (irq !== (n >= 11)) $display("FAIL cmp_irq n=%0d got=%b exp=%b", n, irq, (n >= 11)); else n_pass++;
    end
    bus_read(A_STAT, r);
    n_checks++; if (r[4] !== 1'b1) $display("FAIL cmp_status got=%b exp=1", r[4]); else n_pass++;
    bus_write(A_STAT, 32'h10, 4'b0001);
    n_checks++; if (irq !== 1'b0) $display("FAIL cmp_clear got=%b exp=0", irq); else n_pass++;
    bus_read(A_TMR, r);
    n_checks++; if (r !== model_timer()) $display("FAIL cmp_timer_runs got=%h exp=%h", r, model_timer()); else n_pass++;
    bus_write(A_TMR, 32'd9, 4'hF);
    idle(1);
    bus_write(A_STAT, 32'h10, 4'b0001);
    n_checks++; if (irq !== 1'b1) $display("FAIL cmp_set_wins got=%b exp=1", irq); else n_pass++;
    bus_write(A_STAT, 32'h10, 4'b0010);
    n_checks++; if (irq !== 1'b1) $display("FAIL cmp_clr_lane got=%b exp=1", irq); else n_pass++;
    bus_write(A_STAT, 32'h10, 4'b0001);
    n_checks++; if (irq !== 1'b0) $display("FAIL cmp_clear2 got=%b exp=0", irq); else n_pass++;
  endtask

  task automatic test_uart_frame();
    logic [31:0] r;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'h55);
    fork
      bus_write(A_UTX, 32'h55, 4'b0001);
      sample_line(46, 1'b1);
    join
    bus_read(A_STAT, r);
    n_checks++; if (r[2:0] !== 3'b010) $display("FAIL uart_end_status got=%b exp=010", r[2:0]); else n_pass++;
    b = 8'($urandom);
    frame_q.delete();
    frame_q.push_back(b);
    fork
      bus_write(A_UTX, {24'hABCDEF, b}, 4'b0001);
      sample_line(44, 1'b0);
    join
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [7:0] b [6];
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    frame_q.delete();
    for (int i = 0; i < 5; i++) frame_q.push_back(b[i]);
    bus_write(A_STAT, 32'h08, 4'b0001);
    fork
      for (int i = 0; i < 6; i++) bus_write(A_UTX, 32'(b[i]), 4'b0001);
      sample_line(2 + 5 * 10 * CPB + 8, 1'b0);
    join
    bus_read(A_STAT, r);
    n_checks++; if (r[3] !== 1'b1) $display("FAIL ovf_set got=%b exp=1", r[3]); else n_pass++;
    idle(5);
    bus_write(A_STAT, 32'h10, 4'b0001);
    bus_read(A_STAT, r);
    n_checks++; if (r[3] !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", r[3]); else n_pass++;
    bus_write(A_STAT, 32'h08, 4'b1110);
    bus_read(A_STAT, r);
    n_checks++; if (r[3] !== 1'b1) $display("FAIL ovf_clr_lane got=%b exp=1", r[3]); else n_pass++;
    bus_write(A_STAT, 32'h08, 4'b0001);
    bus_read(A_STAT, r);
    n_checks++; if (r[3:0] !== 4'b0010) $display("FAIL ovf_clear got=%b exp=0010", r[3:0]); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] r;
    int glitches;
    bus_write(A_GOUT, 32'h5A, 4'b0001);
    bus_write(A_UTX, 32'hA3, 4'b0001);
    bus_write(A_UTX, 32'h77, 4'b0001);
    idle(2 + 3 * CPB);
    @(negedge clk) rst = 1'b0;
    idle(1);
    t_val = '0; t_cyc = cyc; m_gpio = '0;
    n_checks++; if (uart_tx !== 1'b1) $display("FAIL mid_rst_uart got=%b exp=1", uart_tx); else n_pass++;
    n_checks++; if (gpio_out !== '0) $display("FAIL mid_rst_gpio got=%h exp=0", gpio_out); else n_pass++;
    bus_read(A_STAT, r);
    n_checks++; if (r !== 32'h2) $display("FAIL mid_rst_status got=%h exp=2", r); else n_pass++;
    bus_read(A_TMR, r);
    n_checks++; if (r !== 32'h0) $display("FAIL mid_rst_timer got=%h exp=0", r); else n_pass++;
    @(negedge clk) rst = 1'b1;
    glitches = 0;
    for (int i = 0; i < 60; i++) begin
      idle(1);
      if (uart_tx !== 1'b1) glitches++;
    end
    n_checks++; if (glitches !== 0) $display("FAIL mid_rst_no_frame got=%0d exp=0", glitches); else n_pass++;
    bus_read(A_TMR, r);
    n_checks++; if (r !== model_timer()) $display("FAIL mid_rst_timer_run got=%h exp=%h", r, model_timer()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_gpio();
    test_timer();
    test_compare();
    test_uart_frame();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
